// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one 4-bit arithmetic unit between two requesters
//
// Purpose:
//    Grants one of two requesters (round-robin on ties) and latches its operands
//    onto a shared combinational arithmetic unit. It holds them for SETTLE_CYCLES,
//    captures the result and returns it over a valid/ready response handshake.
//    Only one operation is in flight at a time.
//
// Ports:
//    i_clk, i_rst                  clock, synchronous active-high reset
//    i_req_valid / o_req_ready     per-requester request handshake (bit i = requester i)
//    i_req_s0/1, i_req_cin0/1      operation select and carry-in per requester
//    i_req_a0/1, i_req_b0/1        operands per requester
//    o_rsp_valid / i_rsp_ready     per-requester response handshake
//    o_rsp_d, o_rsp_cout           captured result, qualified by o_rsp_valid
//    o_au_s/cin/a/b                operands driven to the arithmetic unit
//    i_au_d, i_au_cout             result returned by the arithmetic unit
//    o_grant_cnt0/1                saturating accept counters (only with ARB_STATS_EN)
//
// Optional feature macro: ARB_STATS_EN

module alu_share_arbiter #(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [1:0]       i_req_valid,
   output logic [1:0]       o_req_ready,
   input  logic [1:0]       i_req_s0,
   input  logic [1:0]       i_req_s1,
   input  logic             i_req_cin0,
   input  logic             i_req_cin1,
   input  logic [3:0]       i_req_a0,
   input  logic [3:0]       i_req_a1,
   input  logic [3:0]       i_req_b0,
   input  logic [3:0]       i_req_b1,
   output logic [1:0]       o_rsp_valid,
   input  logic [1:0]       i_rsp_ready,
   output logic [3:0]       o_rsp_d,
   output logic             o_rsp_cout,
   output logic [1:0]       o_au_s,
   output logic             o_au_cin,
   output logic [3:0]       o_au_a,
   output logic [3:0]       o_au_b,
   input  logic [3:0]       i_au_d,
   input  logic             i_au_cout
`ifdef ARB_STATS_EN
   ,
   output logic [7:0]       o_grant_cnt0,
   output logic [7:0]       o_grant_cnt1
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_prio;
   logic             r_gnt;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_rsp_valid;
   logic [3:0]       r_rsp_d;
   logic             r_rsp_cout;
   logic [1:0]       r_au_s;
   logic             r_au_cin;
   logic [3:0]       r_au_a;
   logic [3:0]       r_au_b;

   logic             w_any;
   logic             w_gnt;
   logic             w_accept;
   logic             w_settled;
   logic             w_rsp_done;

   // Tie goes to the priority pointer; a lone requester always wins.
   assign w_any      = |i_req_valid;
   assign w_gnt      = (i_req_valid == 2'b11) ? r_prio : i_req_valid[1];
   assign w_accept   = (r_state == ST_IDLE) && w_any;
   assign w_settled  = (r_state == ST_DRIVE) && (r_cnt == '0);
   assign w_rsp_done = (r_state == ST_RESP) && i_rsp_ready[r_gnt];

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept)   w_state_nxt = ST_DRIVE;
         ST_DRIVE: if (w_settled)  w_state_nxt = ST_RESP;
         ST_RESP:  if (w_rsp_done) w_state_nxt = ST_IDLE;
         default:                  w_state_nxt = ST_IDLE;
      endcase
   end

   // Output logic: request accept is combinational so a grant costs no extra cycle.
   always_comb begin
      o_req_ready = 2'b00;
      if (!i_rst && (r_state == ST_IDLE) && w_any) begin
         o_req_ready[w_gnt] = 1'b1;
      end
   end

   // Operand latch, settle counter, result capture and priority update.
   // The au_* registers are only written on accept so the unit never sees
   // a spurious zero between operations.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_prio      <= 1'b0;
         r_gnt       <= 1'b0;
         r_cnt       <= '0;
         r_rsp_valid <= 2'b00;
         r_rsp_d     <= 4'd0;
         r_rsp_cout  <= 1'b0;
         r_au_s      <= 2'd0;
         r_au_cin    <= 1'b0;
         r_au_a      <= 4'd0;
         r_au_b      <= 4'd0;
      end else begin
         if (w_accept) begin
            r_gnt    <= w_gnt;
            r_cnt    <= CNT_LOAD;
            r_au_s   <= w_gnt ? i_req_s1   : i_req_s0;
            r_au_cin <= w_gnt ? i_req_cin1 : i_req_cin0;
            r_au_a   <= w_gnt ? i_req_a1   : i_req_a0;
            r_au_b   <= w_gnt ? i_req_b1   : i_req_b0;
         end
         if (r_state == ST_DRIVE) begin
            if (w_settled) begin
               r_rsp_d     <= i_au_d;
               r_rsp_cout  <= i_au_cout;
               r_rsp_valid <= r_gnt ? 2'b10 : 2'b01;
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
         end
         if (w_rsp_done) begin
            r_rsp_valid <= 2'b00;
            r_prio      <= ~r_gnt;
         end
      end
   end

   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_d     = r_rsp_d;
   assign o_rsp_cout  = r_rsp_cout;
   assign o_au_s      = r_au_s;
   assign o_au_cin    = r_au_cin;
   assign o_au_a      = r_au_a;
   assign o_au_b      = r_au_b;

`ifdef ARB_STATS_EN
   logic [7:0] r_grant_cnt0;
   logic [7:0] r_grant_cnt1;

   // Saturating per-requester accept counters.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_grant_cnt0 <= 8'd0;
         r_grant_cnt1 <= 8'd0;
      end else if (w_accept) begin
         if (!w_gnt && (r_grant_cnt0 != 8'hFF)) r_grant_cnt0 <= r_grant_cnt0 + 8'd1;
         if ( w_gnt && (r_grant_cnt1 != 8'hFF)) r_grant_cnt1 <= r_grant_cnt1 + 8'd1;
      end
   end

   assign o_grant_cnt0 = r_grant_cnt0;
   assign o_grant_cnt1 = r_grant_cnt1;
`endif

endmodule
